nn_trace_buffer: RTL and testbench

Parametrised on-chip trace capture unit for the neural accelerator datapath. It records a packed per-cycle ALU/address sample (weight, value, accumulator, result, neuron read/write and weight addresses, packed by the accelerator top) into an internal circular RAM. It supports one-shot and trigger-centred ring capture, then plays the capture back oldest-first through a read port. It sits beside `NeuralAccelerator` and replaces file-dump tracing with hardware that also works on silicon.

---
 rtl/nn_trace_buffer.sv | 213 +++++++++++++++++++++
 tb/tb_nn_trace_buffer.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/nn_trace_buffer.sv
// nn_trace_buffer: trace capture RAM for the neural accelerator datapath.
// Records qualified per-cycle samples into a circular RAM in one-shot
// (mode 0) or trigger-centred ring (mode 1) capture, then plays the
// capture back oldest-first through a one-entry-per-cycle read port.
//
// Optional feature macro: NN_TRACE_TIMESTAMP_EN
//   defined   -> each entry is {timestamp[TS_W-1:0], sample_data}
//   undefined -> each entry is sample_data only
//
// Handshake: sample_en qualifies sample_data on the edge it is sampled;
// rd_next is a request sampled on an edge while DONE with entries left,
// and rd_valid is a one-cycle pulse after that edge with rd_data valid.
// rd_next that cannot be served is dropped without a rd_valid pulse.
module nn_trace_buffer #(
  parameter int SAMPLE_W = 48,
  parameter int DEPTH    = 256,
  parameter int PTR_W    = $clog2(DEPTH),
  parameter int TS_W     = 16,
`ifdef NN_TRACE_TIMESTAMP_EN
  localparam int ENTRY_W = SAMPLE_W + TS_W
`else
  localparam int ENTRY_W = SAMPLE_W
`endif
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                arm,
  input  logic                mode,
  input  logic [PTR_W-1:0]    post_count,
  input  logic                sample_en,
  input  logic [SAMPLE_W-1:0] sample_data,
  input  logic                trigger,
  input  logic                rd_next,
  output logic                busy,
  output logic                done,
  output logic                wrapped,
  output logic [PTR_W:0]      count,
  output logic [ENTRY_W-1:0]  rd_data,
  output logic                rd_valid,
  output logic                rd_empty,
  output logic [1:0]          dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ARMED = 2'd1,
    S_POST  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

  // Reject unusable geometries at elaboration time.
  if (DEPTH < 4 || (DEPTH & (DEPTH - 1)) != 0 || TS_W < 1 || SAMPLE_W < 1) begin : g_param_err
    $error("nn_trace_buffer: DEPTH must be a power of two >= 4, widths >= 1");
  end

  logic [ENTRY_W-1:0] mem [DEPTH];

  state_t             state_q;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q;
  logic [PTR_W:0]     count_q, count_d;
  logic [PTR_W:0]     rd_rem_q;
  logic [PTR_W-1:0]   post_rem_q;
  logic [PTR_W-1:0]   post_cfg_q;
  logic               mode_q;
  logic               wrapped_q;
  logic [ENTRY_W-1:0] rd_data_q;
  logic               rd_valid_q;
  logic [PTR_W-1:0]   oldest_d;
  logic [ENTRY_W-1:0] entry_d;
  logic               wr_en;
  logic               rd_fire;
  logic               capturing;

`ifdef NN_TRACE_TIMESTAMP_EN
  logic [TS_W-1:0]    ts_q;
`endif

  assign capturing = (state_q == S_ARMED) || (state_q == S_POST);

  // Write/read qualification and the pointer/count values after this edge.
  always_comb begin
    wr_en    = 1'b0;
    rd_fire  = 1'b0;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    oldest_d = '0;
    wr_en    = sample_en && !arm && !reset && capturing;
    rd_fire  = rd_next && !arm && (state_q == S_DONE) && (rd_rem_q != '0);
    if (wr_en) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (count_q != FULL_CNT) begin
        count_d = count_q + (PTR_W + 1)'(1);
      end
    end
    // Oldest entry sits at the write pointer once the ring is full.
    if (count_d == FULL_CNT) begin
      oldest_d = wr_ptr_d;
    end
  end

  // Entry format: timestamp in the MSBs when stamping is built in.
`ifdef NN_TRACE_TIMESTAMP_EN
  assign entry_d = {ts_q, sample_data};
`else
  assign entry_d = sample_data;
`endif

  // Trace RAM write port; contents survive reset on purpose.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr_q] <= entry_d;
    end
  end

`ifdef NN_TRACE_TIMESTAMP_EN
  // Free-running capture timestamp, zero on the first cycle after arm.
  always_ff @(posedge clk) begin
    if (reset || arm) begin
      ts_q <= '0;
    end else if (capturing) begin
      ts_q <= ts_q + TS_W'(1);
    end
  end
`endif

  // Capture/playback FSM with all pointers, counters and read registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      rd_rem_q   <= '0;
      post_rem_q <= '0;
      post_cfg_q <= '0;
      mode_q     <= 1'b0;
      wrapped_q  <= 1'b0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else if (arm) begin
      state_q    <= S_ARMED;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      wrapped_q  <= 1'b0;
      mode_q     <= mode;
      post_cfg_q <= post_count;
      rd_valid_q <= 1'b0;
    end else begin
      rd_valid_q <= rd_fire;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      case (state_q)
        S_ARMED: begin
          if (!mode_q) begin
            if (wr_en && count_d == FULL_CNT) begin
              state_q  <= S_DONE;
              rd_ptr_q <= oldest_d;
              rd_rem_q <= count_d;
            end
          end else begin
            if (wr_en && count_q == FULL_CNT) begin
              wrapped_q <= 1'b1;
            end
            if (trigger) begin
              if (post_cfg_q == '0) begin
                state_q  <= S_DONE;
                rd_ptr_q <= oldest_d;
                rd_rem_q <= count_d;
              end else begin
                state_q    <= S_POST;
                post_rem_q <= post_cfg_q;
              end
            end
          end
        end
        S_POST: begin
          if (wr_en) begin
            if (count_q == FULL_CNT) begin
              wrapped_q <= 1'b1;
            end
            post_rem_q <= post_rem_q - PTR_W'(1);
            if (post_rem_q == PTR_W'(1)) begin
              state_q  <= S_DONE;
              rd_ptr_q <= oldest_d;
              rd_rem_q <= count_d;
            end
          end
        end
        S_DONE: begin
          if (rd_fire) begin
            rd_data_q <= mem[rd_ptr_q];
            rd_ptr_q  <= rd_ptr_q + PTR_W'(1);
            rd_rem_q  <= rd_rem_q - (PTR_W + 1)'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign busy      = capturing;
  assign done      = (state_q == S_DONE);
  assign wrapped   = wrapped_q;
  assign count     = count_q;
  assign rd_data   = rd_data_q;
  assign rd_valid  = rd_valid_q;
  assign rd_empty  = (state_q == S_DONE) && (rd_rem_q == '0);
  assign dbg_state = state_q;

endmodule

// File: tb/tb_nn_trace_buffer.sv
// tb_nn_trace_buffer: directed checks of nn_trace_buffer at DEPTH=8.
// Covers one-shot, ring/trigger, short ring, timestamped entries (when
// NN_TRACE_TIMESTAMP_EN is defined), reset mid-capture and arm in DONE.
module tb_nn_trace_buffer;

  localparam int SW    = 16;
  localparam int DEPTH = 8;
  localparam int PW    = 3;
  localparam int TSW   = 16;
`ifdef NN_TRACE_TIMESTAMP_EN
  localparam int EW = SW + TSW;
`else
  localparam int EW = SW;
`endif

  logic          clk;
  logic          reset;
  logic          arm;
  logic          mode;
  logic [PW-1:0] post_count;
  logic          sample_en;
  logic [SW-1:0] sample_data;
  logic          trigger;
  logic          rd_next;
  logic          busy;
  logic          done;
  logic          wrapped;
  logic [PW:0]   count;
  logic [EW-1:0] rd_data;
  logic          rd_valid;
  logic          rd_empty;
  logic [1:0]    dbg_state;

  int pass_cnt  = 0;
  int total_cnt = 0;

  nn_trace_buffer #(
    .SAMPLE_W(SW),
    .DEPTH   (DEPTH),
    .TS_W    (TSW)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .arm        (arm),
    .mode       (mode),
    .post_count (post_count),
    .sample_en  (sample_en),
    .sample_data(sample_data),
    .trigger    (trigger),
    .rd_next    (rd_next),
    .busy       (busy),
    .done       (done),
    .wrapped    (wrapped),
    .count      (count),
    .rd_data    (rd_data),
    .rd_valid   (rd_valid),
    .rd_empty   (rd_empty),
    .dbg_state  (dbg_state)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Driver: apply one cycle of inputs at negedge, return 1 time unit after posedge
  task automatic cyc(input logic a, input logic m, input logic [PW-1:0] pc,
                     input logic se, input logic [SW-1:0] sd,
                     input logic tr, input logic rn);
    @(negedge clk);
    arm         = a;
    mode        = m;
    post_count  = pc;
    sample_en   = se;
    sample_data = sd;
    trigger     = tr;
    rd_next     = rn;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    cyc(1'b0, 1'b0, '0, 1'b0, '0, 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle();
    idle();
    total_cnt++; if (busy !== 1'b0) $display("FAIL reset_busy: got %0b want 0", busy); else pass_cnt++;
    total_cnt++; if (done !== 1'b0) $display("FAIL reset_done: got %0b want 0", done); else pass_cnt++;
    total_cnt++; if (count !== 4'd0) $display("FAIL reset_count: got %0d want 0", count); else pass_cnt++;
    total_cnt++; if (rd_valid !== 1'b0) $display("FAIL reset_rd_valid: got %0b want 0", rd_valid); else pass_cnt++;
    total_cnt++; if (rd_empty !== 1'b0) $display("FAIL reset_rd_empty: got %0b want 0", rd_empty); else pass_cnt++;
    total_cnt++; if (dbg_state !== 2'd0) $display("FAIL reset_state: got %0d want 0", dbg_state); else pass_cnt++;
    reset = 1'b0;
  endtask

  task automatic test_oneshot();
    cyc(1'b1, 1'b0, '0, 1'b0, '0, 1'b0, 1'b0);
    for (int k = 1; k <= 10; k++) begin
      cyc(1'b0, 1'b0, '0, 1'b1, SW'(k), 1'b0, 1'b0);
      if (k == 7) begin
        total_cnt++; if (done !== 1'b0 || busy !== 1'b1) $display("FAIL oneshot_k7: done=%0b busy=%0b want 0 1", done, busy); else pass_cnt++;
      end
      if (k == 8) begin
        total_cnt++; if (done !== 1'b1 || busy !== 1'b0) $display("FAIL oneshot_k8: done=%0b busy=%0b want 1 0", done, busy); else pass_cnt++;
      end
    end
    total_cnt++; if (count !== 4'd8) $display("FAIL oneshot_count: got %0d want 8", count); else pass_cnt++;
    total_cnt++; if (wrapped !== 1'b0) $display("FAIL oneshot_wrapped: got %0b want 0", wrapped); else pass_cnt++;
    total_cnt++; if (rd_empty !== 1'b0) $display("FAIL oneshot_not_empty: got %0b want 0", rd_empty); else pass_cnt++;
    for (int i = 0; i < 8; i++) begin
      cyc(1'b0, 1'b0, '0, 1'b0, '0, 1'b0, 1'b1);
      total_cnt++;
      if (rd_valid !== 1'b1 || rd_data[SW-1:0] !== SW'(i + 1))
        $display("FAIL oneshot_play%0d: valid=%0b data=%0d want 1 %0d", i, rd_valid, rd_data[SW-1:0], i + 1);
      else pass_cnt++;
    end
    idle();
    total_cnt++; if (rd_valid !== 1'b0) $display("FAIL oneshot_valid_drop: got %0b want 0", rd_valid); else pass_cnt++;
    total_cnt++; if (rd_empty !== 1'b1) $display("FAIL oneshot_empty: got %0b want 1", rd_empty); else pass_cnt++;
    total_cnt++; if (rd_data[SW-1:0] !== SW'(8)) $display("FAIL oneshot_hold: got %0d want 8", rd_data[SW-1:0]); else pass_cnt++;
  endtask

  task automatic test_ring_wrap();
    cyc(1'b1, 1'b1, 3'd2, 1'b0, '0, 1'b0, 1'b0);
    for (int k = 1; k <= 20; k++) begin
      cyc(1'b0, 1'b0, '0, 1'b1, SW'(k), (k == 12), 1'b0);
      if (k == 13) begin
        total_cnt++; if (dbg_state !== 2'd2 || busy !== 1'b1) $display("FAIL ring_k13: state=%0d busy=%0b want 2 1", dbg_state, busy); else pass_cnt++;
      end
      if (k == 14) begin
        total_cnt++; if (done !== 1'b1 || busy !== 1'b0) $display("FAIL ring_k14: done=%0b busy=%0b want 1 0", done, busy); else pass_cnt++;
      end
    end
    total_cnt++; if (count !== 4'd8) $display("FAIL ring_count: got %0d want 8", count); else pass_cnt++;
    total_cnt++; if (wrapped !== 1'b1) $display("FAIL ring_wrapped: got %0b want 1", wrapped); else pass_cnt++;
    for (int i = 0; i < 8; i++) begin
      cyc(1'b0, 1'b0, '0, 1'b0, '0, 1'b0, 1'b1);
      total_cnt++;
      if (rd_valid !== 1'b1 || rd_data[SW-1:0] !== SW'(i + 7))
        $display("FAIL ring_play%0d: valid=%0b data=%0d want 1 %0d", i, rd_valid, rd_data[SW-1:0], i + 7);
      else pass_cnt++;
    end
    idle();
    total_cnt++; if (rd_empty !== 1'b1) $display("FAIL ring_empty: got %0b want 1", rd_empty); else pass_cnt++;
  endtask

  task automatic test_ring_short();
    cyc(1'b1, 1'b1, 3'd1, 1'b0, '0, 1'b0, 1'b0);
    for (int k = 1; k <= 6; k++) begin
      cyc(1'b0, 1'b0, '0, 1'b1, SW'(k), (k == 3), 1'b0);
    end
    total_cnt++; if (done !== 1'b1) $display("FAIL short_done: got %0b want 1", done); else pass_cnt++;
    total_cnt++; if (count !== 4'd4) $display("FAIL short_count: got %0d want 4", count); else pass_cnt++;
    total_cnt++; if (wrapped !== 1'b0) $display("FAIL short_wrapped: got %0b want 0", wrapped); else pass_cnt++;
    for (int i = 0; i < 4; i++) begin
      cyc(1'b0, 1'b0, '0, 1'b0, '0, 1'b0, 1'b1);
      total_cnt++;
      if (rd_valid !== 1'b1 || rd_data[SW-1:0] !== SW'(i + 1))
        $display("FAIL short_play%0d: valid=%0b data=%0d want 1 %0d", i, rd_valid, rd_data[SW-1:0], i + 1);
      else pass_cnt++;
    end
    cyc(1'b0, 1'b0, '0, 1'b0, '0, 1'b0, 1'b1);
    total_cnt++; if (rd_valid !== 1'b0) $display("FAIL short_extra_rd: got %0b want 0", rd_valid); else pass_cnt++;
    total_cnt++; if (rd_empty !== 1'b1) $display("FAIL short_empty: got %0b want 1", rd_empty); else pass_cnt++;
  endtask

  task automatic test_timestamp();
    logic [SW-1:0] dat [8];
    int            tsv [8];
    logic [EW-1:0] exp_e;
    int            k;
    dat = '{16'hA0A0, 16'hB1B1, 16'hC2C2, 16'hD3D3, 16'hE4E4, 16'hF5F5, 16'h1616, 16'h2727};
    tsv = '{0, 1, 4, 5, 6, 7, 8, 9};
    cyc(1'b1, 1'b0, '0, 1'b0, '0, 1'b0, 1'b0);
    k = 0;
    for (int c = 0; c < 10; c++) begin
      if (c == 2 || c == 3) begin
        cyc(1'b0, 1'b0, '0, 1'b0, 16'hDEAD, 1'b0, 1'b0);
      end else begin
        cyc(1'b0, 1'b0, '0, 1'b1, dat[k], 1'b0, 1'b0);
        k++;
      end
    end
    total_cnt++; if (done !== 1'b1) $display("FAIL ts_done: got %0b want 1", done); else pass_cnt++;
    for (int i = 0; i < 8; i++) begin
`ifdef NN_TRACE_TIMESTAMP_EN
      exp_e = {TSW'(tsv[i]), dat[i]};
`else
      exp_e = dat[i];
      if (tsv[i] < 0) exp_e = '0;
`endif
      cyc(1'b0, 1'b0, '0, 1'b0, '0, 1'b0, 1'b1);
      total_cnt++;
      if (rd_valid !== 1'b1 || rd_data !== exp_e)
        $display("FAIL ts_play%0d: valid=%0b data=%0h want 1 %0h", i, rd_valid, rd_data, exp_e);
      else pass_cnt++;
    end
  endtask

  task automatic test_reset_mid_capture();
    cyc(1'b1, 1'b1, 3'd3, 1'b0, '0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, '0, 1'b1, SW'(1), 1'b0, 1'b0);
    cyc(1'b0, 1'b0, '0, 1'b1, SW'(2), 1'b1, 1'b0);
    total_cnt++; if (dbg_state !== 2'd2 || busy !== 1'b1) $display("FAIL rst_pre: state=%0d busy=%0b want 2 1", dbg_state, busy); else pass_cnt++;
    @(negedge clk);
    reset = 1'b1;
    cyc(1'b0, 1'b0, '0, 1'b1, SW'(3), 1'b0, 1'b0);
    reset = 1'b0;
    total_cnt++; if (busy !== 1'b0 || done !== 1'b0) $display("FAIL rst_flags: busy=%0b done=%0b want 0 0", busy, done); else pass_cnt++;
    total_cnt++; if (count !== 4'd0) $display("FAIL rst_count: got %0d want 0", count); else pass_cnt++;
    total_cnt++; if (dbg_state !== 2'd0) $display("FAIL rst_state: got %0d want 0", dbg_state); else pass_cnt++;
    cyc(1'b1, 1'b0, '0, 1'b0, '0, 1'b0, 1'b0);
    for (int k = 5; k <= 12; k++) begin
      cyc(1'b0, 1'b0, '0, 1'b1, SW'(k), 1'b0, 1'b0);
    end
    total_cnt++; if (done !== 1'b1 || count !== 4'd8) $display("FAIL rst_recap: done=%0b count=%0d want 1 8", done, count); else pass_cnt++;
    for (int i = 0; i < 8; i++) begin
      cyc(1'b0, 1'b0, '0, 1'b0, '0, 1'b0, 1'b1);
      total_cnt++;
      if (rd_valid !== 1'b1 || rd_data[SW-1:0] !== SW'(i + 5))
        $display("FAIL rst_play%0d: valid=%0b data=%0d want 1 %0d", i, rd_valid, rd_data[SW-1:0], i + 5);
      else pass_cnt++;
    end
  endtask

  task automatic test_arm_in_done();
    cyc(1'b1, 1'b1, 3'd0, 1'b0, '0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, '0, 1'b1, SW'(16'h0042), 1'b1, 1'b0);
    total_cnt++; if (done !== 1'b1 || count !== 4'd1) $display("FAIL armdone_pre: done=%0b count=%0d want 1 1", done, count); else pass_cnt++;
    cyc(1'b1, 1'b1, 3'd0, 1'b0, '0, 1'b1, 1'b1);
    total_cnt++; if (dbg_state !== 2'd1 || busy !== 1'b1 || done !== 1'b0) $display("FAIL armdone_state: state=%0d busy=%0b done=%0b want 1 1 0", dbg_state, busy, done); else pass_cnt++;
    total_cnt++; if (count !== 4'd0) $display("FAIL armdone_count: got %0d want 0", count); else pass_cnt++;
    total_cnt++; if (rd_valid !== 1'b0) $display("FAIL armdone_rd_valid: got %0b want 0", rd_valid); else pass_cnt++;
    cyc(1'b0, 1'b0, '0, 1'b1, SW'(16'h0055), 1'b0, 1'b0);
    total_cnt++; if (busy !== 1'b1 || count !== 4'd1) $display("FAIL armdone_next: busy=%0b count=%0d want 1 1", busy, count); else pass_cnt++;
  endtask

  initial begin
    reset       = 1'b1;
    arm         = 1'b0;
    mode        = 1'b0;
    post_count  = '0;
    sample_en   = 1'b0;
    sample_data = '0;
    trigger     = 1'b0;
    rd_next     = 1'b0;
    test_reset();
    test_oneshot();
    test_ring_wrap();
    test_ring_short();
    test_timestamp();
    test_reset_mid_capture();
    test_arm_in_done();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
